// File: rtl/seg_pkg.sv
// Shared types and constants for the scrolling hex-display feeder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package seg_pkg;

    localparam int NIBBLES = 8;
    localparam int DIGITS  = 6;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        S_STATIC = 1'b0,
        S_SCROLL = 1'b1
    } state_e;

    // Rotate a display word left by one nibble; the top nibble wraps to the bottom.
    function automatic logic [31:0] rotl_nibble(input logic [31:0] w);
        return {w[27:0], w[31:28]};
    endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick every TICK_DIV of them.
// Latency: tick is combinational from the count, high on the last cycle of each period.
// Backpressure: none; clr restarts the period and suppresses the count for that cycle.
module seg_tick_div #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    import seg_pkg::*;

    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear wins, then wrap on the last cycle, else count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Feeds six hex digits from a 32-bit word, static or nibble-scrolled (scroll needs SEG_SCROLL_EN).
// Latency: display reflects an accepted word on the cycle after the accept edge.
// Backpressure: wr_ready drops for HOLD_CYCLES cycles after each accept; writes during that time are ignored.
module seg_scroll_ctrl #(
    parameter int TICK_DIV    = 25000000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic        wr_mode,
    output logic        scrolling,
    output logic [3:0]  src0,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic [3:0]  src3,
    output logic [3:0]  src4,
    output logic [3:0]  src5
);
    import seg_pkg::*;

    localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    logic [31:0]   buf_q, buf_d;
    logic [HW-1:0] hold_q, hold_d;
    state_e        state_q, state_d;
    state_e        wr_state;
    logic          accept;
    logic          tick;
    logic [23:0]   window;

    assign wr_ready = (hold_q == '0);
    assign accept   = wr_valid && wr_ready;

`ifdef SEG_SCROLL_EN
    assign wr_state = wr_mode ? S_SCROLL : S_STATIC;

    seg_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (state_q == S_SCROLL),
        .tick (tick)
    );
`else
    // Without scroll support the mode bit and divider setting have no effect.
    logic unused_mode;
    localparam int unused_tick_div = TICK_DIV;
    assign unused_mode = wr_mode;
    assign wr_state    = S_STATIC;
    assign tick        = 1'b0;
`endif

    // Next state: an accept beats a same-cycle tick so new data lands unrotated.
    always_comb begin
        buf_d   = buf_q;
        state_d = state_q;
        hold_d  = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
        if (accept) begin
            buf_d   = wr_data;
            state_d = wr_state;
            hold_d  = HOLD_LOAD;
        end else if (tick) begin
            buf_d   = rotl_nibble(buf_q);
        end
    end

    // State registers; reset overrides any pending write, tick or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            state_q <= S_STATIC;
            hold_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Digit window: low six nibbles when static, nibbles 7..2 of the ring when scrolling.
    always_comb begin
        scrolling = (state_q == S_SCROLL);
        window    = scrolling ? buf_q[31:8] : buf_q[23:0];
        src0      = window[3:0];
        src1      = window[7:4];
        src2      = window[11:8];
        src3      = window[15:12];
        src4      = window[19:16];
        src5      = window[23:20];
    end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Self-checking bench for seg_scroll_ctrl with TICK_DIV=4, HOLD_CYCLES=3.
// Expected display comes from a word/elapsed-cycle model: rotation = (edges since accept)/TICK_DIV.
// Works with or without SEG_SCROLL_EN defined.
module tb_seg_scroll_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int HOLD_CYCLES = 3;
`ifdef SEG_SCROLL_EN
    localparam bit SCROLL_BUILT = 1'b1;
`else
    localparam bit SCROLL_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        wr_mode = 1'b0;
    logic        scrolling;
    logic [3:0]  src0, src1, src2, src3, src4, src5;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: last accepted word, its mode, and clock edges since it was accepted.
    logic [31:0] m_word = '0;
    logic        m_mode = 1'b0;
    int          m_n    = HOLD_CYCLES;

    always #5 clk = ~clk;

    seg_scroll_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_mode   (wr_mode),
        .scrolling (scrolling),
        .src0      (src0),
        .src1      (src1),
        .src2      (src2),
        .src3      (src3),
        .src4      (src4),
        .src5      (src5)
    );

    function automatic logic [31:0] rot_word(input logic [31:0] w, input int steps);
        int r;
        r = steps % 8;
        if (r == 0) return w;
        return (w << (4 * r)) | (w >> (32 - 4 * r));
    endfunction

    // Expected {wr_ready, scrolling, src5..src0}.
    function automatic logic [25:0] model_view();
        logic [31:0] w;
        logic [23:0] d;
        w = m_mode ? rot_word(m_word, m_n / TICK_DIV) : m_word;
        d = m_mode ? w[31:8] : w[23:0];
        return {(m_n >= HOLD_CYCLES), m_mode, d};
    endfunction

    function automatic logic [25:0] dut_view();
        return {wr_ready, scrolling, src5, src4, src3, src2, src1, src0};
    endfunction

    // One clock edge; the model consumes the inputs present at the edge, outputs settle by #1.
    task automatic step();
        bit acc;
        @(posedge clk);
        acc = wr_valid && (m_n >= HOLD_CYCLES);
        if (rst) begin
            m_word = '0;
            m_mode = 1'b0;
            m_n    = HOLD_CYCLES;
        end else if (acc) begin
            m_word = wr_data;
            m_mode = SCROLL_BUILT ? wr_mode : 1'b0;
            m_n    = 0;
        end else begin
            m_n++;
        end
        #1;
    endtask

    task automatic write_word(input logic [31:0] d, input logic m);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_mode  = m;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if (dut_view() !== 26'h2000000)
            $display("FAIL reset_state got=%h want=%h", dut_view(), 26'h2000000);
        else n_pass++;
        n_checks++;
        if (dut_view() !== model_view())
            $display("FAIL reset_model got=%h want=%h", dut_view(), model_view());
        else n_pass++;
    endtask

    task automatic test_static();
        write_word(32'hAB123456, 1'b0);
        n_checks++;
        if ({src5, src4, src3, src2, src1, src0} !== 24'h123456)
            $display("FAIL static_digits got=%h want=123456", {src5, src4, src3, src2, src1, src0});
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (wr_ready !== (i >= HOLD_CYCLES))
                $display("FAIL static_ready cyc=%0d got=%b want=%b", i, wr_ready, (i >= HOLD_CYCLES));
            else n_pass++;
            n_checks++;
            if (dut_view() !== model_view())
                $display("FAIL static_hold cyc=%0d got=%h want=%h", i, dut_view(), model_view());
            else n_pass++;
            step();
        end
    endtask

    task automatic test_scroll();
        logic [23:0] want;
        write_word(32'h01234567, 1'b1);
        for (int i = 0; i <= 32; i++) begin
            n_checks++;
            if (dut_view() !== model_view())
                $display("FAIL scroll_model cyc=%0d got=%h want=%h", i, dut_view(), model_view());
            else n_pass++;
            if (i == 0 || i == 4 || i == 8 || i == 32) begin
                if (!SCROLL_BUILT) want = 24'h234567;
                else if (i == 4) want = 24'h123456;
                else if (i == 8) want = 24'h234567;
                else want = 24'h012345;
                n_checks++;
                if ({src5, src4, src3, src2, src1, src0} !== want)
                    $display("FAIL scroll_digits cyc=%0d got=%h want=%h", i,
                             {src5, src4, src3, src2, src1, src0}, want);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_hold_valid();
        logic [31:0] second;
        int waited;
        second = $urandom;
        write_word($urandom, 1'b0);
        wr_valid = 1'b1;
        wr_data  = second;
        wr_mode  = 1'b0;
        waited   = 0;
        while (wr_ready !== 1'b1 && waited < 10) begin
            n_checks++;
            if (dut_view() !== model_view())
                $display("FAIL hold_ignore cyc=%0d got=%h want=%h", waited, dut_view(), model_view());
            else n_pass++;
            step();
            waited++;
        end
        n_checks++;
        if (waited != HOLD_CYCLES)
            $display("FAIL hold_wait got=%0d want=%0d", waited, HOLD_CYCLES);
        else n_pass++;
        step();
        wr_valid = 1'b0;
        n_checks++;
        if ({src5, src4, src3, src2, src1, src0} !== second[23:0])
            $display("FAIL hold_accept got=%h want=%h", {src5, src4, src3, src2, src1, src0}, second[23:0]);
        else n_pass++;
    endtask

    task automatic test_tick_collision();
        logic [31:0] w2;
        w2 = 32'h89ABCDEF;
        write_word(32'h13579BDF, 1'b1);
        // Three more edges reach the last prescaler count, where the next edge ticks.
        step();
        step();
        step();
        write_word(w2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (dut_view() !== model_view())
                $display("FAIL collide_model cyc=%0d got=%h want=%h", i, dut_view(), model_view());
            else n_pass++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        write_word(32'hFEDCBA98, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (dut_view() !== 26'h2000000)
            $display("FAIL reset_mid got=%h want=%h", dut_view(), 26'h2000000);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            wr_valid = $urandom_range(0, 3) == 0;
            wr_data  = $urandom;
            wr_mode  = $urandom_range(0, 1);
            step();
            n_checks++;
            if (dut_view() !== model_view())
                $display("FAIL random cyc=%0d got=%h want=%h", i, dut_view(), model_view());
            else n_pass++;
        end
        rst      = 1'b0;
        wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static();
        test_scroll();
        test_hold_valid();
        test_tick_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
